// File: rtl/sm4_pkg.sv
// sm4_pkg: shared constants and helpers for the SM4 key schedule.
//   NR        : number of rounds / round keys
//   FK0..FK3  : system parameter XORed into the master key
//   state_t   : key-expansion FSM states
//   sm4_lkey  : key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23)
package sm4_pkg;

    localparam int NR = 32;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    function automatic logic [31:0] sm4_lkey(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// sm4_sbox: SM4 byte substitution, purely combinational 256-entry lookup.
//   a : input byte
//   y : substituted byte
module sm4_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Index 0 sits in the most significant byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    assign y = SBOX[a];

endmodule

// File: rtl/sm4_key_expand.sv
// sm4_key_expand: iterative SM4 key schedule, one round key per cycle.
//   clk, rst_n       : clock, asynchronous active-low reset
//   key_start/key_in : start request and 128-bit master key (MK0 = key_in[127:96])
//   key_clear        : synchronous abort back to IDLE
//   key_ready        : high while idle
//   count_round_out  : CK ROM index; cki_in returns CK one cycle later
//   rk_valid/rk_idx/rk_data : registered round key stream
//   key_done         : pulse alongside rk31
//   rk_rd_idx/rk_rd_data : round-key store read port
// Optional build macro SM4_RK_STORE_EN keeps all 32 round keys in a register
// array for reverse-order (decryption) readout; otherwise rk_rd_data is 0.
module sm4_key_expand
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_start,
    input  logic [127:0] key_in,
    input  logic         key_clear,
    output logic         key_ready,
    output logic [4:0]   count_round_out,
    input  logic [31:0]  cki_in,
    output logic         rk_valid,
    output logic [4:0]   rk_idx,
    output logic [31:0]  rk_data,
    output logic         key_done,
    input  logic [4:0]   rk_rd_idx,
    output logic [31:0]  rk_rd_data
);

    state_t      state;
    logic [4:0]  round;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] x, b, nk;

    assign key_ready = (state == ST_IDLE);

    // The ROM is registered, so ask for the next round's CK one cycle early:
    // PRIME fetches CK0, ROUND r fetches CK(r+1).
    assign count_round_out = (state == ST_ROUND) ? round + 5'd1 : round;

    // cki_in is used straight from the ROM register (XOR3 + S-box + L' path).
    assign x = k1 ^ k2 ^ k3 ^ cki_in;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (.a(x[8*g +: 8]), .y(b[8*g +: 8]));
    end

    assign nk = k0 ^ sm4_lkey(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            round    <= '0;
            k0       <= '0;
            k1       <= '0;
            k2       <= '0;
            k3       <= '0;
            rk_valid <= 1'b0;
            rk_idx   <= '0;
            rk_data  <= '0;
            key_done <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            key_done <= 1'b0;
            if (key_clear) begin
                state   <= ST_IDLE;
                round   <= '0;
                k0      <= '0;
                k1      <= '0;
                k2      <= '0;
                k3      <= '0;
                rk_idx  <= '0;
                rk_data <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (key_start) begin
                        k0    <= key_in[127:96] ^ FK0;
                        k1    <= key_in[95:64]  ^ FK1;
                        k2    <= key_in[63:32]  ^ FK2;
                        k3    <= key_in[31:0]   ^ FK3;
                        round <= '0;
                        state <= ST_PRIME;
                    end
                    ST_PRIME: state <= ST_ROUND;
                    ST_ROUND: begin
                        k0       <= k1;
                        k1       <= k2;
                        k2       <= k3;
                        k3       <= nk;
                        rk_data  <= nk;
                        rk_idx   <= round;
                        rk_valid <= 1'b1;
                        if (round == 5'(NR - 1)) begin
                            key_done <= 1'b1;
                            round    <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            round <= round + 5'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SM4_RK_STORE_EN
    logic [31:0] rk_mem [NR];

    // Survives key_clear on purpose so a decrypt can still read the last schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) rk_mem[i] <= '0;
        end else if (state == ST_ROUND && !key_clear) begin
            rk_mem[round] <= nk;
        end
    end

    assign rk_rd_data = rk_mem[rk_rd_idx];
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rk_rd_idx;
    assign rk_rd_data    = '0;
`endif

endmodule

// File: tb/tb_sm4_key_expand.sv
module tb_sm4_key_expand;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_start = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_clear = 1'b0;
    logic         key_ready;
    logic [4:0]   count_round_out;
    logic [31:0]  cki_in;
    logic         rk_valid;
    logic [4:0]   rk_idx;
    logic [31:0]  rk_data;
    logic         key_done;
    logic [4:0]   rk_rd_idx = '0;
    logic [31:0]  rk_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm4_key_expand dut (
        .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_in(key_in),
        .key_clear(key_clear), .key_ready(key_ready),
        .count_round_out(count_round_out), .cki_in(cki_in),
        .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_data(rk_data),
        .key_done(key_done), .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data)
    );

    // ---------------- reference model ----------------
    localparam logic [0:255][7:0] TB_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // CK_i byte j = (4i+j)*7 mod 256, byte 0 most significant.
    function automatic logic [31:0] ck_of(input logic [4:0] i);
        logic [31:0] r = '0;
        for (int j = 0; j < 4; j++) r = (r << 8) | (((4 * int'(i) + j) * 7) % 256);
        return r;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] v);
        logic [0:255][7:0] sb = TB_SBOX;
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = sb[v[8*j +: 8]];
        return r;
    endfunction

    logic [31:0] ref_rk [32];

    task automatic compute_ref(input logic [127:0] mk);
        logic [31:0] kk [36];
        logic [31:0] fk [4];
        logic [31:0] bb;
        fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350;
        fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
        for (int j = 0; j < 4; j++) kk[j] = mk[127 - 32*j -: 32] ^ fk[j];
        for (int i = 0; i < 32; i++) begin
            bb = tau(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck_of(5'(i)));
            kk[i+4] = kk[i] ^ bb ^ rotl(bb, 13) ^ rotl(bb, 23);
            ref_rk[i] = kk[i+4];
        end
    endtask

    // ---------------- CK ROM model ----------------
    logic        rom_lat0 = 1'b0;
    logic [31:0] ck_q = '0;
    always @(posedge clk) ck_q <= ck_of(count_round_out);
    assign cki_in = rom_lat0 ? ck_of(count_round_out) : ck_q;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives start for one edge; returns at the negedge of cycle 1 (PRIME).
    task automatic send_start(input logic [127:0] k);
        @(negedge clk);
        key_in = k;
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
    endtask

    logic [31:0] cap_rk [32];

    // Full expansion with per-cycle checks. interfere: re-assert start in ROUND 10.
    task automatic run_full(input logic [127:0] k, input bit interfere);
        int pulses = 0, dones = 0, bad = 0;
        compute_ref(k);
        send_start(k);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            key_start = 1'b0;
            if (interfere && c == 12) begin
                key_in = ~k;
                key_start = 1'b1;
            end
            if (key_ready !== (c >= 34)) bad++;
            if (c == 1 && count_round_out !== 5'd0) bad++;
            if (c >= 2 && c <= 32 && count_round_out !== 5'(c - 1)) bad++;
            if (rk_valid) begin
                if (rk_idx !== 5'(pulses) || c != 3 + pulses) bad++;
                if (rk_data !== ref_rk[rk_idx]) bad++;
                cap_rk[rk_idx] = rk_data;
                pulses++;
            end
            if (key_done) begin
                dones++;
                if (c != 34 || rk_idx !== 5'd31) bad++;
            end
        end
        chk("run_pulses", 32'(pulses), 32'd32);
        chk("run_done_pulses", 32'(dones), 32'd1);
        chk("run_cycle_errors", 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [4:0]   idx;
        logic [31:0]  exp;
    } vec_t;

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

    initial begin
        vec_t vt [5];
        logic [127:0] last_key;
        logic [127:0] rk_key;
        int bad, got_rk;

        vt[0] = '{STD_KEY, 5'd0,  32'hF12186F9};
        vt[1] = '{STD_KEY, 5'd1,  32'h41662B61};
        vt[2] = '{STD_KEY, 5'd2,  32'h5A6AB19A};
        vt[3] = '{STD_KEY, 5'd3,  32'h7BA92077};
        vt[4] = '{STD_KEY, 5'd31, 32'h9124A012};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_key_ready", 32'(key_ready), 32'd1);
        chk("rst_rk_valid", 32'(rk_valid), 32'd0);
        chk("rst_rk_idx", 32'(rk_idx), 32'd0);
        chk("rst_rk_data", rk_data, 32'd0);
        chk("rst_key_done", 32'(key_done), 32'd0);
        chk("rst_count", 32'(count_round_out), 32'd0);
        rst_n = 1'b1;

        // table-driven standard vector
        last_key = '1;
        for (int i = 0; i < 5; i++) begin
            if (vt[i].key !== last_key) begin
                run_full(vt[i].key, 1'b0);
                last_key = vt[i].key;
            end
            chk($sformatf("std_rk%0d", vt[i].idx), cap_rk[vt[i].idx], vt[i].exp);
        end

        // store contents persist through key_clear
        @(negedge clk); key_clear = 1'b1;
        @(negedge clk); key_clear = 1'b0;
`ifdef SM4_RK_STORE_EN
        rk_rd_idx = 5'd31; #1 chk("store_rk31", rk_rd_data, 32'h9124A012);
        rk_rd_idx = 5'd0;  #1 chk("store_rk0", rk_rd_data, 32'hF12186F9);
`else
        rk_rd_idx = 5'd31; #1 chk("store_off_zero", rk_rd_data, 32'd0);
`endif

        // ignored start during ROUND 10
        run_full(STD_KEY, 1'b1);
        chk("ignored_start_rk31", cap_rk[31], 32'h9124A012);

        // clear during ROUND 15 (cycle 17)
        send_start(STD_KEY);
        repeat (16) @(negedge clk);
        key_clear = 1'b1;
        @(negedge clk);
        key_clear = 1'b0;
        chk("clr_key_ready", 32'(key_ready), 32'd1);
        chk("clr_rk_valid", 32'(rk_valid), 32'd0);
        chk("clr_rk_data", rk_data, 32'd0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (key_done || rk_valid) bad++;
        end
        chk("clr_no_done", 32'(bad), 32'd0);
        run_full(STD_KEY, 1'b0);
        chk("clr_restart_rk0", cap_rk[0], 32'hF12186F9);

        // async reset during ROUND 20 (cycle 22)
        send_start(STD_KEY);
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ares_key_ready", 32'(key_ready), 32'd1);
        chk("ares_rk_valid", 32'(rk_valid), 32'd0);
        chk("ares_rk_data", rk_data, 32'd0);
        chk("ares_rk_idx", 32'(rk_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rk_key = {$urandom, $urandom, $urandom, $urandom};
        run_full(rk_key, 1'b0);

        // random keys against the model
        for (int n = 0; n < 4; n++) begin
            rk_key = {$urandom, $urandom, $urandom, $urandom};
            run_full(rk_key, 1'b0);
            chk($sformatf("rand%0d_rk31", n), cap_rk[31], ref_rk[31]);
        end

        // a zero-latency ROM feeds the wrong CK, so rk0 must differ
        compute_ref(STD_KEY);
        rom_lat0 = 1'b1;
        send_start(STD_KEY);
        got_rk = 0;
        for (int c = 0; c < 40 && got_rk == 0; c++) begin
            if (rk_valid) begin
                got_rk = 1;
                checks++;
                if (rk_data === ref_rk[0]) begin
                    errors++;
                    $display("FAIL rom_lat0_rk0 got=%h expected_not=%h", rk_data, ref_rk[0]);
                end
            end else begin
                @(negedge clk);
            end
        end
        chk("rom_lat0_seen", 32'(got_rk), 32'd1);
        repeat (40) @(negedge clk);
        rom_lat0 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm4_key_expand.md
Name: sm4_key_expand

Overview:
- Iterative SM4 key-schedule engine for the SM4 core.
- Takes the 128-bit master key (MK), XORs it with FK, then produces the 32 round keys rk0..rk31 at one key per cycle.
- Drives the round index to the registered CK constant ROM (`get_cki`) and consumes its 32-bit CK output.
- Sits between the key register bank and the round datapath.

Parameters:
- NR, 32, number of rounds (fixed by SM4; the counter is 5 bits wide).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_start  in  1  request to expand key_in; accepted when key_start & key_ready.
- key_in  in  128  MK, MK0 = key_in[127:96].
- key_clear  in  1  synchronous abort; returns the block to IDLE.
- key_ready  out  1  high in IDLE.
- count_round_out  out  5  round index to the CK ROM.
- cki_in  in  32  CK value from the ROM, valid one cycle after its index is driven.
- rk_valid  out  1  rk_data/rk_idx valid this cycle.
- rk_idx  out  5  index of rk_data.
- rk_data  out  32  round key.
- key_done  out  1  one-cycle pulse coincident with rk_idx = 31.
- rk_rd_idx  in  5  storage read index (optional feature).
- rk_rd_data  out  32  storage read data (optional feature).

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE, round = 0, K0..K3 = 0.
  - rk_valid = 0, rk_idx = 0, rk_data = 0, key_done = 0, key_ready = 1.
  - Reset mid-expansion aborts with no key_done.
- FSM states: IDLE, PRIME, ROUND.
- IDLE:
  - key_ready = 1.
  - On key_start, load K_j = MK_j ^ FK_j with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Set round = 0 and go to PRIME.
- PRIME:
  - One cycle; count_round_out = 0.
  - Go to ROUND.
- ROUND r (r = 0..31):
  - count_round_out = r+1 (5-bit wrap; the value driven at r = 31 is don't-care). cki_in therefore equals CK_r in this cycle.
  - Compute X = K1^K2^K3^cki_in.
  - Compute tau(X) with 4 byte S-boxes, B = tau(X).
  - Compute new = K0 ^ B ^ (B<<<13) ^ (B<<<23).
  - Shift K0<=K1, K1<=K2, K2<=K3, K3<=new.
  - Register rk_data<=new, rk_idx<=r, rk_valid<=1.
  - If r = 31: key_done<=1, go to IDLE. Otherwise round<=r+1.
- Outputs are registered. rk_valid/key_done are low in every cycle not following a ROUND cycle.
- count_round_out is combinational from state/round: PRIME or IDLE drives round; ROUND drives round+1.
- Latency, with the accept edge at cycle 0:
  - PRIME in cycle 1; ROUND in cycles 2..33.
  - rk_r is visible in cycle 3+r; rk31 and key_done in cycle 34.
  - key_ready = 1 from cycle 34.
- key_start while not key_ready: ignored, not queued.
- key_clear:
  - Takes priority over key_start and rounds.
  - Next state IDLE; K, round and outputs cleared; no key_done.
  - key_clear with key_start in IDLE: the start is dropped.
- cki_in is used unregistered in the ROUND datapath. The critical path is XOR3 + S-box + L'.

Optional Feature:
- SM4_RK_STORE_EN defined:
  - 32x32 register array written with each rk_r at index r.
  - rk_rd_data = array[rk_rd_idx] (combinational); supports reverse-order decryption.
  - Array cleared on reset; not cleared by key_clear.
- Undefined: no array; rk_rd_data tied 0; rk_rd_idx unused.

Decomposition:
- Package sm4_pkg:
  - FK0..FK3 constants.
  - NR.
  - State enum type.
  - Function sm4_lkey(B) implementing B^(B<<<13)^(B<<<23).
- Sub-module sm4_sbox: combinational 8-bit in / 8-bit out 256-entry lookup, instantiated 4 times. It is shared with the round datapath.

Test Plan:
- Standard vector:
  - Stimulus: key_in = 0123456789ABCDEFFEDCBA9876543210.
  - Expected: rk0 = F12186F9 in cycle 3, rk1 = 41662B61, rk2 = 5A6AB19A, rk3 = 7BA92077, rk31 = 9124A012 with key_done in cycle 34.
  - Checks: exactly 32 rk_valid pulses; rk_idx 0..31 in order.
- Ignored start: key_start reasserted with a different key during ROUND cycle 10 -> ignored; rk31 still 9124A012; key_ready is 0 until cycle 34.
- Clear mid-run: key_clear during ROUND r = 15 -> next cycle IDLE, rk_valid = 0, no key_done. A restart with the standard key reproduces rk0 = F12186F9.
- Async reset mid-run: rst_n low during ROUND r = 20 -> outputs 0 and key_ready = 1 immediately. After release, a fresh expansion is correct.
- ROM handshake: check count_round_out = 0 in PRIME and r+1 in ROUND r. A ROM model with 1-cycle latency yields correct keys; a 0-latency model yields mismatches.
- With SM4_RK_STORE_EN: after the standard run, rk_rd_idx = 31 -> 9124A012 and rk_rd_idx = 0 -> F12186F9. Values persist across key_clear.
